// File: rtl/maxnet_ctrl.sv
// Sequencing controller for the Maxnet datapath: load, first pass from memory,
// feedback iterations until convergence or MAX_ITER, then a valid/ack result hold.
module maxnet_ctrl #(
    parameter int unsigned MAX_ITER = 64,
    parameter int unsigned PU_LAT   = 1,
    parameter int unsigned ITER_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ack,
    input  logic              dp_done,
    input  logic [31:0]       dp_max,
    output logic              ld,
    output logic              sel,
    output logic              busy,
    output logic              res_valid,
    output logic [31:0]       result,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int unsigned CNT_W = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PU_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_ITER,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ITER_W-1:0] iter_next;
    logic              win_end;

    assign iter_next = iter_count + ITER_W'(1);
    assign win_end   = (cnt == CNT_LAST);

    // Single-process FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ld         <= 1'b0;
            sel        <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            result     <= '0;
            timeout    <= 1'b0;
            iter_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        cnt        <= '0;
                        ld         <= 1'b1;
                        busy       <= 1'b1;
                        sel        <= 1'b0;
                        res_valid  <= 1'b0;
                        iter_count <= '0;
                        timeout    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state <= S_INIT;
                    ld    <= 1'b0;
                    cnt   <= '0;
                end
                S_INIT: begin
                    if (win_end) begin
                        state <= S_ITER;
                        sel   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ITER: begin
                    if (win_end) begin
                        cnt        <= '0;
                        iter_count <= iter_next;
                        // Convergence takes priority over hitting the iteration limit.
                        if (dp_done || (iter_next == ITER_MAX)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            result    <= dp_max;
                            timeout   <= ~dp_done;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        cnt        <= '0;
                        ld         <= 1'b1;
                        busy       <= 1'b1;
                        sel        <= 1'b0;
                        res_valid  <= 1'b0;
                        iter_count <= '0;
                        timeout    <= 1'b0;
                    end else if (out_ack) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        sel       <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: two parameterisations driven by shared stimulus and checked
// every cycle against a run-timeline reference model, plus directed timing points.
module tb_maxnet_ctrl;

    localparam int P_A = 1;
    localparam int M_A = 4;
    localparam int P_B = 2;
    localparam int M_B = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, out_ack, dp_done;
    logic [31:0] dp_max;

    logic        ld_a, sel_a, busy_a, rv_a, to_a;
    logic [31:0] res_a;
    logic [2:0]  it_a;
    logic        ld_b, sel_b, busy_b, rv_b, to_b;
    logic [31:0] res_b;
    logic [2:0]  it_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] max6;

    typedef struct {
        bit          running;
        bit          in_done;
        int          s;
        logic        ld, sel, busy, rv, timeout;
        logic [31:0] result;
        int          iter;
    } model_t;

    model_t ma, mb;

    maxnet_ctrl #(.MAX_ITER(M_A), .PU_LAT(P_A), .ITER_W(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .out_ack(out_ack), .dp_done(dp_done),
        .dp_max(dp_max), .ld(ld_a), .sel(sel_a), .busy(busy_a), .res_valid(rv_a),
        .result(res_a), .timeout(to_a), .iter_count(it_a)
    );

    maxnet_ctrl #(.MAX_ITER(M_B), .PU_LAT(P_B), .ITER_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .out_ack(out_ack), .dp_done(dp_done),
        .dp_max(dp_max), .ld(ld_b), .sel(sel_b), .busy(busy_b), .res_valid(rv_b),
        .result(res_b), .timeout(to_b), .iter_count(it_b)
    );

    always #5 clk = ~clk;

    function automatic model_t mreset();
        model_t m;
        m.running = 0; m.in_done = 0; m.s = 0;
        m.ld = 0; m.sel = 0; m.busy = 0; m.rv = 0; m.timeout = 0;
        m.result = '0; m.iter = 0;
        return m;
    endfunction

    // Run timeline: e = cycles since start was accepted; window k is sampled at e = 1 + p*(k+1).
    function automatic model_t step(model_t m, int c, int p, int mit,
                                    bit st, bit ak, bit dn, logic [31:0] mv);
        model_t n = m;
        int e, k;
        if (m.running) begin
            e = c - m.s;
            n.ld   = 0;
            n.busy = 1;
            n.sel  = (e + 1 >= 2 + p);
            if (e >= 1 + 2 * p && ((e - 1) % p) == 0) begin
                k = (e - 1) / p - 1;
                n.iter = k;
                if (dn || k == mit) begin
                    n.running = 0; n.in_done = 1; n.busy = 0; n.rv = 1;
                    n.result = mv; n.timeout = !dn; n.sel = 1;
                end
            end
        end else if (st) begin
            n.running = 1; n.in_done = 0; n.s = c;
            n.ld = 1; n.busy = 1; n.sel = 0; n.rv = 0; n.iter = 0; n.timeout = 0;
        end else if (m.in_done && ak) begin
            n.in_done = 0; n.rv = 0; n.sel = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_dut(input string p, input model_t m, input logic l, input logic s,
                             input logic b, input logic v, input logic [31:0] r,
                             input logic t, input logic [2:0] it);
        check({p, ".ld"}, 32'(l), 32'(m.ld));
        check({p, ".sel"}, 32'(s), 32'(m.sel));
        check({p, ".busy"}, 32'(b), 32'(m.busy));
        check({p, ".res_valid"}, 32'(v), 32'(m.rv));
        check({p, ".result"}, r, m.result);
        check({p, ".timeout"}, 32'(t), 32'(m.timeout));
        check({p, ".iter_count"}, 32'(it), 32'(m.iter));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = step(ma, cyc, P_A, M_A, start, out_ack, dp_done, dp_max);
            mb = step(mb, cyc, P_B, M_B, start, out_ack, dp_done, dp_max);
        end
        cyc++;
        #1;
        check_dut("a", ma, ld_a, sel_a, busy_a, rv_a, res_a, to_a, it_a);
        check_dut("b", mb, ld_b, sel_b, busy_b, rv_b, res_b, to_b, it_b);
    endtask

    initial begin
        rst = 1'b0; start = 0; out_ack = 0; dp_done = 0; dp_max = '0;
        ma = mreset(); mb = mreset();
        repeat (3) tick();
        check("reset.busy_a", 32'(busy_a), 32'd0);
        check("reset.iter_b", 32'(it_b), 32'd0);
        rst = 1'b1;
        tick();

        // Convergence at the first window, PU_LAT=1
        start = 1; dp_done = 1; dp_max = 32'h3F80_0000;
        tick();
        start = 0;
        check("conv.ld_c1", 32'(ld_a), 32'd1);
        tick();
        check("conv.ld_c2", 32'(ld_a), 32'd0);
        check("conv.sel_c2", 32'(sel_a), 32'd0);
        tick();
        check("conv.sel_c3", 32'(sel_a), 32'd1);
        check("conv.rv_c3", 32'(rv_a), 32'd0);
        tick();
        check("conv.rv_c4", 32'(rv_a), 32'd1);
        check("conv.result", res_a, 32'h3F80_0000);
        check("conv.iter", 32'(it_a), 32'd1);
        check("conv.timeout", 32'(to_a), 32'd0);
        repeat (3) tick();
        dp_done = 0;
        out_ack = 1;
        tick();
        out_ack = 0;
        check("ack.rv_a", 32'(rv_a), 32'd0);
        check("ack.sel_a", 32'(sel_a), 32'd0);
        check("ack.rv_b", 32'(rv_b), 32'd0);

        // Timeout with MAX_ITER=4 plus a start pulse while busy
        start = 1; dp_max = $urandom;
        tick();
        for (int cy = 1; cy <= 6; cy++) begin
            start  = (cy == 3);
            dp_max = $urandom;
            if (cy == 6) begin
                max6 = dp_max;
                check("tmo.rv_c6", 32'(rv_a), 32'd0);
            end
            tick();
        end
        start = 0;
        check("tmo.rv_c7", 32'(rv_a), 32'd1);
        check("tmo.timeout", 32'(to_a), 32'd1);
        check("tmo.iter", 32'(it_a), 32'd4);
        check("tmo.result", res_a, max6);
        repeat (8) tick();
        check("tmo.rv_b", 32'(rv_b), 32'd1);
        check("tmo.iter_b", 32'(it_b), 32'd5);
        out_ack = 1;
        tick();
        out_ack = 0;

        // PU_LAT=2: off-window dp_done pulse ignored, convergence at window 3
        start = 1; dp_done = 0;
        tick();
        start = 0;
        for (int cy = 1; cy <= 9; cy++) begin
            dp_done = (cy == 6 || cy == 9);
            dp_max  = 32'h1000_0000 + 32'(cy);
            if (cy == 9) check("pul.rv_c9", 32'(rv_b), 32'd0);
            tick();
        end
        dp_done = 0;
        check("pul.rv_c10", 32'(rv_b), 32'd1);
        check("pul.iter_b", 32'(it_b), 32'd3);
        check("pul.timeout_b", 32'(to_b), 32'd0);
        check("pul.result_b", res_b, 32'h1000_0009);
        check("pul.tie_timeout_a", 32'(to_a), 32'd0);
        check("pul.tie_iter_a", 32'(it_a), 32'd4);

        // start and out_ack together in DONE
        start = 1; out_ack = 1;
        tick();
        start = 0; out_ack = 0;
        check("both.ld_b", 32'(ld_b), 32'd1);
        check("both.rv_b", 32'(rv_b), 32'd0);
        check("both.iter_b", 32'(it_b), 32'd0);
        check("both.timeout_a", 32'(to_a), 32'd0);

        // Asynchronous reset in the middle of ITER
        repeat (4) tick();
        check("mid.sel_b", 32'(sel_b), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        ma = mreset(); mb = mreset();
        check("mid.busy_b", 32'(busy_b), 32'd0);
        check("mid.sel_b0", 32'(sel_b), 32'd0);
        check("mid.iter_b", 32'(it_b), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        start = 1;
        tick();
        start = 0;
        repeat (12) tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(399) != 0);
            start   = ($urandom_range(7) == 0);
            out_ack = ($urandom_range(3) == 0);
            dp_done = ($urandom_range(5) == 0);
            dp_max  = $urandom;
            if (!rst) begin
                #1;
                ma = mreset(); mb = mreset();
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
